sbox_ti_share_gen: RTL
======================

// Module: sbox_ti_share_gen
// PURPOSE
//  Input masking stage that sits directly upstream of the threshold-implementation (TI) S-box component functions.
//  Accepts one unmasked 4-bit S-box input per transaction.
//  Splits it into SHARES Boolean shares using fresh randomness from an internal LFSR.
//  Presents the registered share vector to the first TI stage; share slices from this vector drive the component-function inputs.
//  Invariant: XOR of all output shares == accepted input nibble.
// PARAMETERS
//  SHARES  3         number of Boolean shares, >=2
//  NIB     4         S-box input width in bits
//  LFSR_W  16        LFSR width; must be >= (SHARES-1)*NIB
//  TAPS    16'hB400  Fibonacci feedback mask: x^16+x^14+x^13+x^11+1
//  SEED    16'hACE1  LFSR value loaded at reset; a value of 0 is replaced by 1
// PORTS
//  clk         in   1                clock, rising edge
//  rst         in   1                synchronous reset, active-high
//  in_valid    in   1                in_data is valid
//  in_ready    out  1                block can accept in_data this cycle
//  in_data     in   NIB              unmasked S-box input
//  out_valid   out  1                out_shares is valid
//  out_ready   in   1                downstream TI stage takes out_shares
//  out_shares  out  SHARES*NIB       share i at [i*NIB +: NIB]
//  seed_load   in   1                (TI_RESEED_EN only) reseed request
//  seed        in   LFSR_W           (TI_RESEED_EN only) new LFSR value
// BEHAVIOUR
//  Reset values:
//   - out_valid=0, out_shares=0
//   - lfsr=SEED, or 1 if SEED is 0
//   - state=READY, cnt=0
//   - Reset has priority over every other event; asserting it mid-REFILL or mid-WARM returns the block to READY and discards pending output.
//  Masks are taken from the current LFSR value: share i = lfsr[i*NIB +: NIB] for i < SHARES-1.
//  Last share = in_data ^ XOR of those masks.
//  FSM states:
//   - READY:
//     - in_ready = !out_valid | out_ready.
//     - Accept when in_valid & in_ready: out_shares is registered and out_valid=1 on the next edge (1-cycle latency).
//     - Then go to REFILL with cnt=(SHARES-1)*NIB.
//   - REFILL:
//     - in_ready=0.
//     - LFSR shifts once per cycle: lfsr <= {lfsr[LFSR_W-2:0], ^(lfsr & TAPS)}; cnt decrements.
//     - When cnt reaches 1, the block returns to READY on that edge.
//     - Result: no mask bit is reused between consecutive samples.
//   - The LFSR holds its value in READY; it advances only in REFILL (and WARM).
//  Output handshake:
//   - out_valid & !out_ready holds out_shares and out_valid stable.
//   - Transfer occurs when out_valid & out_ready; out_valid drops next cycle unless a new accept happens in that same cycle.
//  Simultaneous output pop and input accept in READY: new shares are loaded, out_valid stays 1, and there is no bubble.
//  Lockup guard: if the LFSR ever equals 0, it is forced to 1 on the next edge.
//  Throughput: one sample per 1+(SHARES-1)*NIB cycles (9 at defaults).
// CONFIGURATION
//  Macro TI_RESEED_EN defined:
//   - Ports seed_load and seed exist.
//   - seed_load, sampled in any state, wins over an accept in the same cycle.
//   - It loads lfsr=seed (0 is replaced by 1) and drops any in-progress REFILL.
//   - Next state is WARM: cnt=LFSR_W and in_ready=0, then LFSR steps until cnt reaches 0, then READY.
//   - The pending out_shares/out_valid is kept.
//  Macro not defined:
//   - No reseed ports and no WARM state; the LFSR is seeded only by SEED at reset.
// TESTING
//  1. Reset: assert rst 2 cycles -> in_ready=1, out_valid=0, out_shares=0.
//  2. Defaults, in_data=4'hA accepted at cycle 0, out_ready=1 -> cycle 1: out_valid=1, out_shares=12'h5E1 (shares 1,E,5); in_ready=0 for 8 cycles, then 1.
//  3. out_ready=0 held 20 cycles after an accept -> out_shares stable, in_ready stays 0 after REFILL; on out_ready=1 with in_valid=1, pop and accept in the same cycle, out_valid never drops.
//  4. rst asserted at cycle 3 of REFILL -> next cycle READY, out_valid=0, lfsr=SEED; a replay of scenario 2 reproduces 12'h5E1.
//  5. 1000 random in_data with random out_ready -> XOR of shares == in_data for every transfer; no two consecutive transfers use equal mask sets; the LFSR never equals 0.
//  6. TI_RESEED_EN: seed_load with seed=0 at the same cycle as in_valid -> accept ignored, lfsr=1, in_ready=0 for 16 cycles, then READY.

Source files
------------

// File: rtl/sbox_ti_share_gen.sv
// Input masking stage for the TI S-box: splits one nibble into SHARES Boolean shares
// using LFSR randomness. Optional reseed port and WARM state under macro TI_RESEED_EN.
//
// state  | meaning
// -------+---------------------------------------------------------------
// READY  | waiting for a sample; LFSR holds its value
// REFILL | shifting (SHARES-1)*NIB fresh bits into the LFSR after an accept
// WARM   | (TI_RESEED_EN) stepping LFSR_W times after a reseed

module sbox_ti_share_gen #(
    parameter int                SHARES = 3,
    parameter int                NIB    = 4,
    parameter int                LFSR_W = 16,
    parameter logic [LFSR_W-1:0] TAPS   = 16'hB400,
    parameter logic [LFSR_W-1:0] SEED   = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [NIB-1:0]        in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SHARES*NIB-1:0] out_shares
`ifdef TI_RESEED_EN
    ,
    input  logic                  seed_load,
    input  logic [LFSR_W-1:0]     seed
`endif
);

    localparam int                CNT_W      = $clog2(LFSR_W + 1);
    localparam logic [CNT_W-1:0]  REFILL_CNT = CNT_W'((SHARES - 1) * NIB);
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
    localparam logic [LFSR_W-1:0] LFSR_ONE   = {{(LFSR_W-1){1'b0}}, 1'b1};
    localparam logic [LFSR_W-1:0] SEED_INIT  = (SEED == '0) ? LFSR_ONE : SEED;
`ifdef TI_RESEED_EN
    localparam logic [CNT_W-1:0]  WARM_CNT   = CNT_W'(LFSR_W);
`endif

    typedef enum logic [1:0] {
        ST_READY  = 2'd0,
        ST_REFILL = 2'd1
`ifdef TI_RESEED_EN
        ,
        ST_WARM   = 2'd2
`endif
    } state_t;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic [LFSR_W-1:0]   lfsr, lfsr_nxt, lfsr_step;
    logic [NIB-1:0]      mask_xor;
    logic [SHARES*NIB-1:0] share_nxt;
    logic                accept;
    logic                shift;
    logic                reseed;

`ifdef TI_RESEED_EN
    logic [LFSR_W-1:0]   seed_safe;
    assign reseed    = seed_load;
    assign seed_safe = (seed == '0) ? LFSR_ONE : seed;
`else
    assign reseed    = 1'b0;
`endif

    assign lfsr_step = {lfsr[LFSR_W-2:0], ^(lfsr & TAPS)};

    // Mask shares come straight from the low LFSR slices; the last share absorbs the data.
    always_comb begin
        mask_xor  = '0;
        share_nxt = '0;
        for (int i = 0; i < SHARES - 1; i++) begin
            share_nxt[i*NIB +: NIB] = lfsr[i*NIB +: NIB];
            mask_xor                = mask_xor ^ lfsr[i*NIB +: NIB];
        end
        share_nxt[(SHARES-1)*NIB +: NIB] = in_data ^ mask_xor;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_READY;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        in_ready  = 1'b0;
        accept    = 1'b0;
        shift     = 1'b0;
        case (state)
            ST_READY: begin
                in_ready = (!out_valid || out_ready) && !reseed;
                accept   = in_valid && in_ready;
                if (accept) begin
                    state_nxt = ST_REFILL;
                    cnt_nxt   = REFILL_CNT;
                end
            end
            ST_REFILL: begin
                shift   = 1'b1;
                cnt_nxt = cnt - CNT_ONE;
                if (cnt <= CNT_ONE) begin
                    state_nxt = ST_READY;
                end
            end
`ifdef TI_RESEED_EN
            ST_WARM: begin
                shift   = 1'b1;
                cnt_nxt = cnt - CNT_ONE;
                if (cnt <= CNT_ONE) begin
                    state_nxt = ST_READY;
                end
            end
`endif
            default: begin
                state_nxt = ST_READY;
                cnt_nxt   = '0;
            end
        endcase
`ifdef TI_RESEED_EN
        // A reseed drops any refill in flight and restarts warm-up from the new value.
        if (reseed) begin
            state_nxt = ST_WARM;
            cnt_nxt   = WARM_CNT;
            shift     = 1'b0;
        end
`endif
    end

    always_comb begin
        lfsr_nxt = lfsr;
`ifdef TI_RESEED_EN
        if (reseed) begin
            lfsr_nxt = seed_safe;
        end else
`endif
        if (lfsr == '0) begin
            lfsr_nxt = LFSR_ONE;
        end else if (shift) begin
            lfsr_nxt = lfsr_step;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= SEED_INIT;
        end else begin
            lfsr <= lfsr_nxt;
        end
    end

    // A pop and an accept in the same cycle reload the register without a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_shares <= '0;
        end else if (accept) begin
            out_valid  <= 1'b1;
            out_shares <= share_nxt;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

endmodule
